// File: rtl/bilateral_ctrl_if.sv
// Signal bundle between bilateral_ctrl, its frame SRAM, the filter core and the result sink.
interface bilateral_ctrl_if;
  logic              in_valid;
  logic signed [8:0] in_data;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic signed [8:0] mem_wdata;
  logic signed [8:0] mem_rdata;
  logic              win_valid;
  logic [3:0]        win_idx;
  logic signed [8:0] win_data;
  logic              win_last;
  logic              core_valid;
  logic signed [8:0] core_data;
  logic              out_valid;
  logic [15:0]       out_addr;
  logic signed [8:0] out_data;
  logic              busy;

  modport master (
    input  in_valid, in_data, mem_rdata, core_valid, core_data,
    output mem_we, mem_addr, mem_wdata, win_valid, win_idx, win_data, win_last,
           out_valid, out_addr, out_data, busy
  );

  modport slave (
    output in_valid, in_data, mem_rdata, core_valid, core_data,
    input  mem_we, mem_addr, mem_wdata, win_valid, win_idx, win_data, win_last,
           out_valid, out_addr, out_data, busy
  );
endinterface

// File: rtl/bilateral_ctrl.sv
// Frame buffer + 3x3 window sequencer + tag tracker for a bilateral filter core.
// Define BILAT_ZERO_PAD_EN to zero-pad out-of-frame taps instead of replicating edges.
module bilateral_ctrl #(
  parameter int IMG_LOG2  = 8,
  parameter int TAG_DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  bilateral_ctrl_if.master bus
);
  localparam int AW = 2 * IMG_LOG2;
  localparam int SW = IMG_LOG2 + 2;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [AW-1:0]        LAST_ADDR = '1;
  localparam logic signed [SW-1:0] MAX_C     = SW'((1 << IMG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FETCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] wr_cnt, ctr_addr, out_cnt;
  logic [3:0]    tap;
  logic [AW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] tag_cnt;

  logic                 wr_en, issue, push, pop, pad;
  logic signed [SW-1:0] dy, dx, row_s, col_s;
  logic [AW-1:0]        rd_addr;

  logic              mem_we_p0, rd_vld_p0, pad_p0;
  logic [AW-1:0]     mem_addr_p0;
  logic signed [8:0] mem_wdata_p0;
  logic [3:0]        idx_p0;
  logic              vld_p1, pad_p1;
  logic [3:0]        idx_p1;
  logic              res_vld_p0;
  logic [AW-1:0]     res_addr_p0;
  logic signed [8:0] res_data_p0;

  function automatic logic [IMG_LOG2-1:0] sat_coord(input logic signed [SW-1:0] v);
    if (v[SW-1])   return '0;
    if (v > MAX_C) return '1;
    return v[IMG_LOG2-1:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_en = bus.in_valid && (state == IDLE || state == LOAD);
  // A window only starts when a tag slot is free, so it is never split.
  assign issue = (state == FETCH) && !(tap == 4'd0 && tag_cnt == CW'(TAG_DEPTH));
  assign push  = issue && (tap == 4'd0);
  assign pop   = bus.core_valid && (tag_cnt != '0);

  always_comb begin
    dy = (tap < 4'd3) ? SW'(-1) : (tap < 4'd6) ? SW'(0) : SW'(1);
    case (tap)
      4'd0, 4'd3, 4'd6: dx = SW'(-1);
      4'd1, 4'd4, 4'd7: dx = SW'(0);
      default:          dx = SW'(1);
    endcase
    row_s   = $signed({2'b00, ctr_addr[AW-1:IMG_LOG2]}) + dy;
    col_s   = $signed({2'b00, ctr_addr[IMG_LOG2-1:0]}) + dx;
    rd_addr = {sat_coord(row_s), sat_coord(col_s)};
  end

`ifdef BILAT_ZERO_PAD_EN
  function automatic logic in_range(input logic signed [SW-1:0] v);
    return !v[SW-1] && (v <= MAX_C);
  endfunction
  assign pad = !(in_range(row_s) && in_range(col_s));
`else
  assign pad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = LOAD;
      LOAD:    if (wr_en && wr_cnt == LAST_ADDR) state_nxt = FETCH;
      FETCH:   if (issue && tap == 4'd8 && ctr_addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (res_vld_p0 && out_cnt == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt   <= '0;
      ctr_addr <= '0;
      tap      <= '0;
      out_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (issue) begin
        if (tap == 4'd8) begin
          tap      <= '0;
          ctr_addr <= ctr_addr + 1'b1;
        end else begin
          tap <= tap + 4'd1;
        end
      end
      if (res_vld_p0) out_cnt <= out_cnt + 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= ctr_addr;
  end

  // p0: SRAM port; a padded tap leaves the address untouched (no real read)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_p0    <= 1'b0;
      rd_vld_p0    <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      idx_p0       <= '0;
      pad_p0       <= 1'b0;
    end else begin
      mem_we_p0 <= wr_en;
      rd_vld_p0 <= issue;
      if (wr_en) begin
        mem_addr_p0  <= wr_cnt;
        mem_wdata_p0 <= bus.in_data;
      end else if (issue) begin
        idx_p0 <= tap;
        pad_p0 <= pad;
        if (!pad) mem_addr_p0 <= rd_addr;
      end
    end
  end

  // p1: read data returns, window tap presented to the core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      pad_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_vld_p0;
      idx_p1 <= idx_p0;
      pad_p1 <= pad_p0;
    end
  end

  // result stage: core output tagged with its centre address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld_p0  <= 1'b0;
      res_addr_p0 <= '0;
      res_data_p0 <= '0;
    end else begin
      res_vld_p0 <= pop;
      if (pop) begin
        res_addr_p0 <= tag_mem[rd_ptr];
        res_data_p0 <= bus.core_data;
      end
    end
  end

  assign bus.mem_we    = mem_we_p0;
  assign bus.mem_addr  = 16'(mem_addr_p0);
  assign bus.mem_wdata = mem_wdata_p0;
  assign bus.win_valid = vld_p1;
  assign bus.win_idx   = idx_p1;
  assign bus.win_data  = (vld_p1 && !pad_p1) ? bus.mem_rdata : '0;
  assign bus.win_last  = vld_p1 && (idx_p1 == 4'd8);
  assign bus.out_valid = res_vld_p0;
  assign bus.out_addr  = 16'(res_addr_p0);
  assign bus.out_data  = res_data_p0;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_bilateral_ctrl.sv
// Directed bench for bilateral_ctrl on an 8x8 frame with SRAM and 20-cycle echo-core models.
module tb_bilateral_ctrl;
  localparam int LG   = 3;
  localparam int SIDE = 1 << LG;
  localparam int N    = SIDE * SIDE;
  localparam int TD   = 8;
  localparam int PER  = 10;

  logic clk = 1'b0;
  logic rst;
  always #(PER/2) clk = ~clk;

  bilateral_ctrl_if bus();
  bilateral_ctrl #(.IMG_LOG2(LG), .TAG_DEPTH(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int frame_f = 0;
  int exp_wr = 0, exp_win_c = 0, exp_win_t = 0, exp_out = 0, win_last_cnt = 0;
  longint first_wr_t = 0, last_wr_t = 0, last_out_t = 0;
  bit core_hold = 1'b0;
  int tap4 = 0;

  typedef struct { longint t; int d; } core_item_t;
  core_item_t core_q[$];
  logic signed [8:0] mem [0:65535];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int f, input int a);
    case (f)
      0:       return a;
      1:       return -1 - a;
      default: return ((a * 37) % 512) - 256;
    endcase
  endfunction

  function automatic int tap_exp(input int f, input int c, input int t);
    int r, q;
    r = c / SIDE + t / 3 - 1;
    q = c % SIDE + t % 3 - 1;
`ifdef BILAT_ZERO_PAD_EN
    if (r < 0 || r >= SIDE || q < 0 || q >= SIDE) return 0;
`endif
    if (r < 0) r = 0;
    if (r >= SIDE) r = SIDE - 1;
    if (q < 0) q = 0;
    if (q >= SIDE) q = SIDE - 1;
    return pix(f, r * SIDE + q);
  endfunction

  // SRAM model: read data valid one cycle after the address
  initial begin
    int a;
    logic signed [8:0] nxt;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      a = int'(bus.mem_addr);
      if (bus.mem_we) mem[a] = bus.mem_wdata;
      nxt = mem[a];
      @(posedge clk);
      #1 bus.mem_rdata = nxt;
    end
  end

  // Core model: echoes the centre tap 20 cycles after each window completes
  initial begin
    core_item_t it;
    bus.core_valid = 1'b0;
    bus.core_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.win_valid && bus.win_idx == 4'd4) tap4 = int'($signed(bus.win_data));
      if (bus.win_valid && bus.win_last) begin
        it.t = $time + 20 * PER;
        it.d = tap4;
        core_q.push_back(it);
      end
      if (!core_hold && core_q.size() > 0 && core_q[0].t <= $time) begin
        bus.core_valid = 1'b1;
        bus.core_data  = 9'(core_q[0].d);
        void'(core_q.pop_front());
      end else begin
        bus.core_valid = 1'b0;
      end
    end
  end

  // Stream monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (bus.mem_we) begin
        check("wr_addr", int'(bus.mem_addr), exp_wr);
        check("wr_data", int'($signed(bus.mem_wdata)), pix(frame_f, exp_wr));
        check("wr_in_load", int'(exp_wr < N), 1);
        if (exp_wr == 0) first_wr_t = $time;
        last_wr_t = $time;
        exp_wr++;
      end
      if (bus.win_valid) begin
        check("win_idx", int'(bus.win_idx), exp_win_t);
        check("win_data", int'($signed(bus.win_data)), tap_exp(frame_f, exp_win_c, exp_win_t));
        check("win_last", int'(bus.win_last), int'(exp_win_t == 8));
        if (exp_win_t == 8) begin
          exp_win_t = 0;
          exp_win_c++;
          win_last_cnt++;
        end else begin
          exp_win_t++;
        end
      end
      if (bus.out_valid) begin
        check("out_addr", int'(bus.out_addr), exp_out);
        check("out_data", int'($signed(bus.out_data)), pix(frame_f, exp_out));
        check("out_not_in_load", int'(bus.mem_we), 0);
        if (exp_out == N - 1) last_out_t = $time;
        exp_out++;
      end
    end
  end

  task automatic new_frame(input int f);
    frame_f = f;
    exp_wr = 0; exp_win_c = 0; exp_win_t = 0; exp_out = 0; win_last_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 9'h0AA;
    #1 check("rst_async_busy", int'(bus.busy), 0);
    new_frame(frame_f);
    repeat (2) @(negedge clk);
    check("rst_mem_we", int'(bus.mem_we), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_mem_wdata", int'(bus.mem_wdata), 0);
    check("rst_win_valid", int'(bus.win_valid), 0);
    check("rst_win_idx", int'(bus.win_idx), 0);
    check("rst_win_data", int'(bus.win_data), 0);
    check("rst_win_last", int'(bus.win_last), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_addr", int'(bus.out_addr), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_busy", int'(bus.busy), 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic load_frame(input int f, input bit gaps, input int stop_at);
    for (int a = 0; a < N; a++) begin
      if (a == stop_at) break;
      @(posedge clk);
      #1;
      if (gaps && (a % 7 == 3)) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 9'(pix(f, a));
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, int'(n < 8000), 1);
    check({tag, "_idle_lag"}, int'(($time - last_out_t) / PER), 1);
    check({tag, "_writes"}, exp_wr, N);
    check({tag, "_windows"}, win_last_cnt, N);
    check({tag, "_outputs"}, exp_out, N);
    check({tag, "_busy_end"}, int'(bus.busy), 0);
  endtask

  initial begin
    #(PER * 50000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    do_reset();

    // Gapless ramp frame; extra in_valid during FETCH must be ignored
    new_frame(0);
    load_frame(0, 1'b0, N);
    check("busy_into_fetch", int'(bus.busy), 1);
    repeat (20) begin
      @(posedge clk);
      #1 bus.in_valid = 1'b1;
      bus.in_data = 9'h1FF;
    end
    bus.in_valid = 1'b0;
    check("wr_span", int'((last_wr_t - first_wr_t) / PER), N - 1);
    wait_done("f0");

    // Negative pixels with input gaps
    new_frame(1);
    load_frame(1, 1'b1, N);
    wait_done("f1");

    // Core stalls: issue stops after TAG_DEPTH windows, then resumes losslessly
    new_frame(2);
    core_hold = 1'b1;
    load_frame(2, 1'b0, N);
    repeat (200) @(negedge clk);
    check("stall_windows", win_last_cnt, TD);
    check("stall_outputs", exp_out, 0);
    core_hold = 1'b0;
    wait_done("stall");

    // Reset mid-FETCH: late core results must be discarded
    new_frame(1);
    load_frame(1, 1'b0, N);
    repeat (60) @(posedge clk);
    do_reset();
    repeat (40) @(negedge clk);
    check("stale_out", exp_out, 0);
    check("stale_busy", int'(bus.busy), 0);

    // Reset mid-LOAD, then a full fresh frame
    new_frame(0);
    load_frame(0, 1'b0, 30);
    do_reset();
    new_frame(2);
    load_frame(2, 1'b0, N);
    wait_done("restart");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
